// File: rtl/count_checker.sv
// count_checker: sequence checker for a free-running up/down counter bus.
// Each sample must be exactly one step (+1 or -1, wrapping) from the
// previous one. After LOCK_CYCLES consecutive good steps the checker locks;
// any break while locked raises a one-cycle error pulse, sets a sticky flag,
// bumps a saturating error count and captures the offending value, then
// drops back to acquisition, resynchronised to the bad value.
module count_checker #(
  parameter int WIDTH       = 3,
  parameter int DIR         = 0,
  parameter int LOCK_CYCLES = 4,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     c_in,
  input  logic                 err_clr,
  output logic                 locked,
  output logic                 err_pulse,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [WIDTH-1:0]     last_bad
);

  typedef enum logic {ACQUIRE = 1'b0, LOCKED = 1'b1} state_t;

  // run is 4 bits wide, so the lock threshold is expressed in that width.
  localparam logic [3:0] LOCK_RUN = 4'(LOCK_CYCLES);

  state_t           state;
  logic [WIDTH-1:0] prev;
  logic             have_prev;
  logic [3:0]       run;
  logic [WIDTH-1:0] exp_val;
  logic             step_ok;

  // Next value the counter should present, wrapping modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] next_exp(input logic [WIDTH-1:0] p);
    if (DIR == 0) next_exp = p + WIDTH'(1);
    else          next_exp = p - WIDTH'(1);
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
    if (&c) sat_inc = c;
    else    sat_inc = c + ERR_CNT_W'(1);
  endfunction

  // Step comparison against the previous sample.
  assign exp_val = next_exp(prev);
  assign step_ok = (c_in == exp_val);

  // Checker FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ACQUIRE;
      prev       <= '0;
      have_prev  <= 1'b0;
      run        <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      err_count  <= '0;
      last_bad   <= '0;
    end else begin
      // Always track the latest sample; on an error this resynchronises
      // the checker to the bad value.
      prev      <= c_in;
      have_prev <= 1'b1;
      err_pulse <= 1'b0;

      // A clear on its own empties the error record; an error detected in
      // the same cycle overrides it below.
      if (err_clr) begin
        err_sticky <= 1'b0;
        err_count  <= '0;
      end

      case (state)
        ACQUIRE: begin
          if (have_prev) begin
            if (step_ok) begin
              run <= run + 4'd1;
              if (run + 4'd1 == LOCK_RUN) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              // Breaks while acquiring just restart the good-step run.
              run <= '0;
            end
          end
        end

        LOCKED: begin
          if (!step_ok) begin
            err_pulse  <= 1'b1;
            err_sticky <= 1'b1;
            last_bad   <= c_in;
            err_count  <= err_clr ? ERR_CNT_W'(1) : sat_inc(err_count);
            state      <= ACQUIRE;
            locked     <= 1'b0;
            run        <= '0;
          end
        end

        default: begin
          state  <= ACQUIRE;
          locked <= 1'b0;
          run    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_checker.sv
// Directed testbench for count_checker: an up checker, a down checker and an
// up checker with a 2-bit error counter all watch the same driven bus.
module tb_count_checker;

  logic       clk;
  logic       rst;
  logic [2:0] c_in;
  logic       err_clr;

  logic       up_locked, up_pulse, up_sticky;
  logic [7:0] up_count;
  logic [2:0] up_bad;
  logic       dn_locked, dn_pulse, dn_sticky;
  logic [7:0] dn_count;
  logic [2:0] dn_bad;
  logic       st_locked, st_pulse, st_sticky;
  logic [1:0] st_count;
  logic [2:0] st_bad;

  int checks;
  int failures;
  logic [2:0] v;

  count_checker #(.WIDTH(3), .DIR(0), .LOCK_CYCLES(4), .ERR_CNT_W(8)) dut_up (
    .clk(clk), .rst(rst), .c_in(c_in), .err_clr(err_clr),
    .locked(up_locked), .err_pulse(up_pulse), .err_sticky(up_sticky),
    .err_count(up_count), .last_bad(up_bad)
  );

  count_checker #(.WIDTH(3), .DIR(1), .LOCK_CYCLES(4), .ERR_CNT_W(8)) dut_dn (
    .clk(clk), .rst(rst), .c_in(c_in), .err_clr(err_clr),
    .locked(dn_locked), .err_pulse(dn_pulse), .err_sticky(dn_sticky),
    .err_count(dn_count), .last_bad(dn_bad)
  );

  count_checker #(.WIDTH(3), .DIR(0), .LOCK_CYCLES(4), .ERR_CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .c_in(c_in), .err_clr(err_clr),
    .locked(st_locked), .err_pulse(st_pulse), .err_sticky(st_sticky),
    .err_count(st_count), .last_bad(st_bad)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Present a sample, let one edge take it, and return 1 time unit later.
  task automatic drive(input logic [2:0] val);
    c_in = val;
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges, check the cleared state, then release.
  task automatic do_reset();
    rst = 1'b0;
    err_clr = 1'b0;
    c_in = 3'd0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_locked", up_locked, 0);
    check("rst_count", up_count, 0);
    check("rst_bad", up_bad, 0);
    rst = 1'b1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    c_in = 3'd0;
    err_clr = 1'b0;

    // Lock counting up, across the 7->0 wrap.
    do_reset();
    drive(3'd0);
    drive(3'd1); drive(3'd2); drive(3'd3);
    check("up_not_yet", up_locked, 0);
    drive(3'd4);
    check("up_lock_e5", up_locked, 1);
    drive(3'd5); drive(3'd6); drive(3'd7);
    drive(3'd0);
    check("up_wrap_pulse", up_pulse, 0);
    drive(3'd1);
    check("up_wrap_count", up_count, 0);
    check("up_wrap_locked", up_locked, 1);
    check("up_wrap_sticky", up_sticky, 0);

    // Single glitch: 2,3, then 6 instead of 4.
    drive(3'd2); drive(3'd3);
    drive(3'd6);
    check("gl_pulse", up_pulse, 1);
    check("gl_count", up_count, 1);
    check("gl_sticky", up_sticky, 1);
    check("gl_bad", up_bad, 6);
    check("gl_unlock", up_locked, 0);
    drive(3'd7);
    check("gl_pulse_1cyc", up_pulse, 0);
    drive(3'd0); drive(3'd1);
    check("gl_not_relock", up_locked, 0);
    drive(3'd2);
    check("gl_relock", up_locked, 1);
    drive(3'd3);
    // Back-to-back bad samples: only the first is an error.
    drive(3'd6);
    check("b2b_first", up_count, 2);
    drive(3'd1);
    check("b2b_pulse", up_pulse, 0);
    check("b2b_count", up_count, 2);
    check("b2b_bad", up_bad, 6);

    // Lock counting down, across the 0->7 wrap.
    do_reset();
    drive(3'd7);
    drive(3'd6); drive(3'd5); drive(3'd4);
    check("dn_not_yet", dn_locked, 0);
    drive(3'd3);
    check("dn_lock_e5", dn_locked, 1);
    drive(3'd2); drive(3'd1); drive(3'd0);
    drive(3'd7);
    check("dn_wrap_pulse", dn_pulse, 0);
    check("dn_wrap_count", dn_count, 0);
    check("dn_wrap_locked", dn_locked, 1);

    // Error while acquiring: no report, run restarts at the 3.
    do_reset();
    drive(3'd0); drive(3'd1);
    drive(3'd3);
    check("acq_pulse", up_pulse, 0);
    drive(3'd4); drive(3'd5); drive(3'd6);
    check("acq_not_yet", up_locked, 0);
    drive(3'd7);
    check("acq_lock", up_locked, 1);
    check("acq_sticky", up_sticky, 0);
    check("acq_count", up_count, 0);

    // Saturation with a 2-bit counter, then clear behaviour.
    do_reset();
    v = 3'd0;
    drive(v);
    for (int i = 0; i < 4; i++) begin v = v + 3'd1; drive(v); end
    check("sat_locked", st_locked, 1);
    for (int e = 0; e < 5; e++) begin
      v = v + 3'd3;
      drive(v);
      for (int i = 0; i < 4; i++) begin v = v + 3'd1; drive(v); end
    end
    check("sat_count", st_count, 3);
    v = v + 3'd2;
    drive(v);
    check("sat_pulse", st_pulse, 1);
    check("sat_bad", st_bad, 32'(v));
    check("sat_hold", st_count, 3);
    for (int i = 0; i < 4; i++) begin v = v + 3'd1; drive(v); end
    err_clr = 1'b1;
    v = v + 3'd1;
    drive(v);
    err_clr = 1'b0;
    check("clr_count", st_count, 0);
    check("clr_sticky", st_sticky, 0);
    check("clr_keep_bad", st_bad, 32'(v - 3'd5));
    err_clr = 1'b1;
    v = v + 3'd3;
    drive(v);
    err_clr = 1'b0;
    check("clr_err_count", st_count, 1);
    check("clr_err_sticky", st_sticky, 1);

    // Asynchronous reset while locked with two errors recorded.
    do_reset();
    drive(3'd0); drive(3'd1); drive(3'd2); drive(3'd3); drive(3'd4);
    drive(3'd7);
    drive(3'd0); drive(3'd1); drive(3'd2); drive(3'd3);
    drive(3'd6);
    drive(3'd7); drive(3'd0); drive(3'd1); drive(3'd2);
    check("ar_pre_count", up_count, 2);
    check("ar_pre_locked", up_locked, 1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_locked", up_locked, 0);
    check("ar_count", up_count, 0);
    check("ar_sticky", up_sticky, 0);
    check("ar_bad", up_bad, 0);
    check("ar_pulse", up_pulse, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(3'd0); drive(3'd1); drive(3'd2); drive(3'd3);
    check("ar_not_yet", up_locked, 0);
    drive(3'd4);
    check("ar_relock", up_locked, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/count_checker.md
# count_checker

Sequence checker for the free-running 3-bit up/down counter outputs produced by the counter top level. It samples one counter bus every clock and checks that each value is exactly one step (+1 or −1, modulo 2^WIDTH) from the previous sample. It acquires lock after a run of good steps, then reports any break in the sequence with an error pulse, a sticky flag, a saturating error count and the offending value. One instance is placed per counter output (c_up, c_down, c_up_2, ...), with DIR set to match.

## Interface
- WIDTH, 3: width of the checked counter bus.
- DIR, 0: expected direction; 0 = increment, 1 = decrement.
- LOCK_CYCLES, 4: consecutive good steps required to enter LOCKED; legal range 1..15.
- ERR_CNT_W, 8: width of the error counter.

- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset; clears all state immediately.
- c_in  input  WIDTH  counter value under check, sampled every clk.
- err_clr  input  1  synchronous clear of err_sticky and err_count.
- locked  output  1  high while the FSM is in LOCKED.
- err_pulse  output  1  one-cycle pulse per sequence break detected while locked.
- err_sticky  output  1  set by any error; cleared only by err_clr or rst.
- err_count  output  ERR_CNT_W  number of errors detected; saturates at all-ones.
- last_bad  output  WIDTH  c_in value that caused the most recent error.

## Operation
- Internal registers:
  - prev[WIDTH-1:0]: previous sample.
  - have_prev: 1 once prev is valid.
  - run[3:0]: count of consecutive good steps.
  - state: ACQUIRE or LOCKED.
- Expected value: exp = prev + 1 when DIR=0, exp = prev − 1 when DIR=1. The result is truncated to WIDTH bits, so it wraps: 7→0 going up, 0→7 going down.
- Every cycle, prev <= c_in and have_prev <= 1.
- ACQUIRE:
  - have_prev=0: load prev only. No comparison is made.
  - c_in == exp: run <= run+1. When the new run value equals LOCK_CYCLES, state <= LOCKED and run is held.
  - c_in != exp: run <= 0. No error is reported while acquiring.
- LOCKED:
  - c_in == exp: stay in LOCKED.
  - c_in != exp:
    - err_pulse <= 1, err_sticky <= 1, last_bad <= c_in.
    - err_count <= err_count+1, unless already all-ones.
    - state <= ACQUIRE, run <= 0.
    - prev <= c_in, so the checker resynchronises to the bad value.
- err_clr:
  - Alone: err_sticky <= 0 and err_count <= 0.
  - Same cycle as an error: the error wins, giving err_sticky=1 and err_count=1.
  - last_bad is not cleared by err_clr.
- Reset (asynchronous, any time, including mid-run or mid-error):
  - state=ACQUIRE, have_prev=0, run=0, prev=0.
  - locked=0, err_pulse=0, err_sticky=0, err_count=0, last_bad=0.
  - After rst deasserts, the first edge loads prev only.

## Timing
- All outputs are registered. There is no combinational path from c_in or err_clr to any output.
- Error latency: c_in is sampled at edge N. If it is bad while locked, err_pulse, err_sticky, err_count and last_bad update at edge N and are visible during cycle N+1. locked falls at the same edge.
- err_pulse is high for exactly one cycle per bad sample.
- Lock latency from reset release, with a correct counter:
  - Edge 1 loads prev.
  - Edges 2..LOCK_CYCLES+1 are good steps.
  - locked rises at edge LOCK_CYCLES+1, which is edge 5 for the default.
- Back-to-back bad samples while locked: only the first reports an error. The checker is already in ACQUIRE for the second.
- A relock after an error needs LOCK_CYCLES further good steps.
- err_count saturation: at all-ones, further errors still pulse err_pulse and update last_bad, but err_count holds.

## Test plan
- Lock, DIR=0: release rst, drive 0,1,2,...,7,0,1 -> locked=1 from edge 5; across the 7→0 wrap err_pulse stays 0 and err_count stays 0.
- Lock, DIR=1: drive 7,6,...,0,7 -> locked=1 from edge 5; the 0→7 wrap produces no error.
- Single glitch: while locked, replace an expected 4 with 6, then continue 7,0,1,2,3 ->
  - one-cycle err_pulse; err_count=1; err_sticky=1; last_bad=6; locked=0.
  - locked returns 4 edges after the glitch sample, since 6→7→0→1→2 gives 4 good steps.
- Error during acquire: drive 0,1,3,4,5,6,7 -> no err_pulse; run resets at the 3; locked rises on the sample 7.
- Saturation and clear, ERR_CNT_W=2: cause 5 errors while locked -> err_count=3; then assert err_clr alone -> count=0, sticky=0; then error and err_clr together -> count=1, sticky=1.
- Async reset mid-lock: pull rst low between edges while locked with err_count=2 -> all outputs 0 immediately without a clk edge; after release, relock takes 5 edges.
